// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, UNROLL bits per cycle.
// Optional define MD_EARLY_OUT_EN adds single-cycle results for zero multiplies and |rs1|<|rs2| divides.
module rv_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset,
    input  logic            MD_start,
    input  logic [2:0]      MD_funct3,
    input  logic [XLEN-1:0] MD_rs1_data,
    input  logic [XLEN-1:0] MD_rs2_data,
    input  logic            MD_flush,
    output logic            MD_ready,
    output logic            MD_busy,
    output logic            MD_done,
    output logic [XLEN-1:0] MD_result
);
    localparam int K  = XLEN / UNROLL;
    localparam int CW = $clog2(K);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   result_q, result_d;

    // accept-time decode
    logic              acc_signed_a, acc_signed_b;
    logic              acc_neg_a, acc_neg_b;
    logic [XLEN-1:0]   acc_mag_a, acc_mag_b;
    logic              acc_is_div;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_res;

    // iteration datapath
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;

    // sign fix-up
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        acc_is_div   = MD_funct3[2];
        acc_signed_a = MD_funct3[2] ? ~MD_funct3[0]
                                    : (MD_funct3[1:0] == 2'b01 || MD_funct3[1:0] == 2'b10);
        acc_signed_b = MD_funct3[2] ? ~MD_funct3[0] : (MD_funct3[1:0] == 2'b01);
        acc_neg_a    = acc_signed_a & MD_rs1_data[XLEN-1];
        acc_neg_b    = acc_signed_b & MD_rs2_data[XLEN-1];
        acc_mag_a    = acc_neg_a ? -MD_rs1_data : MD_rs1_data;
        acc_mag_b    = acc_neg_b ? -MD_rs2_data : MD_rs2_data;

        fast_hit = 1'b0;
        fast_res = '0;
        if (acc_is_div && MD_rs2_data == '0) begin
            fast_hit = 1'b1;
            fast_res = MD_funct3[1] ? MD_rs1_data : '1;
        end else if (acc_is_div && acc_signed_a && MD_rs1_data == {1'b1, {(XLEN-1){1'b0}}}
                     && MD_rs2_data == '1) begin
            fast_hit = 1'b1;
            fast_res = MD_funct3[1] ? '0 : MD_rs1_data;
        end
`ifdef MD_EARLY_OUT_EN
        else if (!acc_is_div && (MD_rs1_data == '0 || MD_rs2_data == '0)) begin
            fast_hit = 1'b1;
            fast_res = '0;
        end else if (acc_is_div && acc_mag_a < acc_mag_b) begin
            fast_hit = 1'b1;
            fast_res = MD_funct3[1] ? MD_rs1_data : '0;
        end
`else
`endif
    end

    // hi:lo is the product (multiply) or remainder:quotient (divide); lo shifts in either case
    always_comb begin
        step_hi  = hi_q;
        step_lo  = lo_q;
        mul_sum  = '0;
        div_sh   = '0;
        div_diff = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (funct3_q[2]) begin
                div_sh   = {step_hi, step_lo[XLEN-1]};
                div_diff = div_sh - {1'b0, m_q};
                if (!div_diff[XLEN]) begin
                    step_hi = div_diff[XLEN-1:0];
                    step_lo = {step_lo[XLEN-2:0], 1'b1};
                end else begin
                    step_hi = div_sh[XLEN-1:0];
                    step_lo = {step_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                mul_sum = {1'b0, step_hi} + (step_lo[0] ? {1'b0, m_q} : '0);
                step_lo = {mul_sum[0], step_lo[XLEN-1:1]};
                step_hi = mul_sum[XLEN:1];
            end
        end
    end

    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_s  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        rem_s  = neg_a_q ? -hi_q : hi_q;
        case (funct3_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        funct3_d = funct3_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (MD_start) begin
                    funct3_d = MD_funct3;
                    neg_a_d  = acc_neg_a;
                    neg_b_d  = acc_neg_b;
                    cnt_d    = '0;
                    hi_d     = '0;
                    lo_d     = acc_is_div ? acc_mag_a : acc_mag_b;
                    m_d      = acc_is_div ? acc_mag_b : acc_mag_a;
                    if (fast_hit) begin
                        state_d  = DONE;
                        result_d = fast_res;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) state_d = FIX;
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        // flush wins over accept and over the FIX result write
        if (MD_flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            funct3_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            funct3_q <= funct3_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
        end
    end

    assign MD_ready  = (state_q == IDLE);
    assign MD_busy   = (state_q != IDLE);
    assign MD_done   = (state_q == DONE);
    assign MD_result = result_q;

endmodule
